// File: rtl/rot_arbiter.sv
// Round-robin arbiter that shares one pipelined word rotator between NUM_REQ requesters.
// Each transaction latches the winner's bus, waits out the rotator latency, captures the result and strobes resp_valid once.
module rot_arbiter #(
  parameter int  BUS_SIZE  = 60,
  parameter int  WORD_SIZE = 6,
  parameter int  NUM_REQ   = 4,
  parameter int  LATENCY   = 1,
  localparam int WORD_NUM  = BUS_SIZE / WORD_SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*BUS_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [BUS_SIZE-1:0]         rot_data_in,
  input  logic [BUS_SIZE-1:0]         rot_data_out,
  input  logic [WORD_NUM-1:0]         rot_control_out,
  input  logic                        rot_error,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [BUS_SIZE-1:0]         resp_data,
  output logic [WORD_NUM-1:0]         resp_control,
  output logic                        resp_error,
  output logic                        busy,
  output logic [7:0]                  err_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     last_r, last_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [NUM_REQ-1:0]   grant_r, grant_s;
  logic [BUS_SIZE-1:0]  rot_data_r, rot_data_s;
  logic [NUM_REQ-1:0]   resp_valid_r, resp_valid_s;
  logic [BUS_SIZE-1:0]  resp_data_r, resp_data_s;
  logic [WORD_NUM-1:0]  resp_control_r, resp_control_s;
  logic                 resp_error_r, resp_error_s;
  logic                 busy_r, busy_s;
  logic [7:0]           err_count_r, err_count_s;

  logic [BUS_SIZE-1:0]  req_bus_s [NUM_REQ];
  logic                 sel_found_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [IDX_W-1:0]     scan_idx_s;
  logic                 take_s;
  int                   scan_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bus
    assign req_bus_s[g] = req_data[g*BUS_SIZE +: BUS_SIZE];
  end

  // Round-robin pick: first asserted request scanning from last+1, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = last_r;
    scan_s      = 0;
    scan_idx_s  = last_r;
    take_s      = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_s      = int'(last_r) + k;
      scan_s      = (scan_s >= NUM_REQ) ? (scan_s - NUM_REQ) : scan_s;
      scan_idx_s  = IDX_W'(scan_s);
      take_s      = !sel_found_s && req[scan_idx_s];
      sel_idx_s   = take_s ? scan_idx_s : sel_idx_s;
      sel_found_s = sel_found_s | take_s;
    end
  end

  // Next-state and next-output logic for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_s        = state_r;
    last_s         = last_r;
    cnt_s          = cnt_r;
    grant_s        = grant_r;
    rot_data_s     = rot_data_r;
    resp_valid_s   = resp_valid_r;
    resp_data_s    = resp_data_r;
    resp_control_s = resp_control_r;
    resp_error_s   = resp_error_r;
    busy_s         = busy_r;
    err_count_s    = err_count_r;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_s    = ST_WAIT;
          grant_s    = ONE_HOT0 << sel_idx_s;
          rot_data_s = req_bus_s[sel_idx_s];
          last_s     = sel_idx_s;
          cnt_s      = CNT_LOAD;
          busy_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s        = ST_RESP;
          resp_valid_s   = grant_r;
          resp_data_s    = rot_data_out;
          resp_control_s = rot_control_out;
          resp_error_s   = rot_error;
          if (rot_error && (err_count_r != 8'hFF)) begin
            err_count_s = err_count_r + 8'd1;
          end else begin
            err_count_s = err_count_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RESP: begin
        state_s      = ST_IDLE;
        resp_valid_s = {NUM_REQ{1'b0}};
        grant_s      = {NUM_REQ{1'b0}};
        busy_s       = 1'b0;
      end
      default: begin
        state_s      = ST_IDLE;
        resp_valid_s = {NUM_REQ{1'b0}};
        grant_s      = {NUM_REQ{1'b0}};
        cnt_s        = {CNT_W{1'b0}};
        busy_s       = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      last_r         <= LAST_RST;
      cnt_r          <= {CNT_W{1'b0}};
      grant_r        <= {NUM_REQ{1'b0}};
      rot_data_r     <= {BUS_SIZE{1'b0}};
      resp_valid_r   <= {NUM_REQ{1'b0}};
      resp_data_r    <= {BUS_SIZE{1'b0}};
      resp_control_r <= {WORD_NUM{1'b0}};
      resp_error_r   <= 1'b0;
      busy_r         <= 1'b0;
      err_count_r    <= 8'd0;
    end else begin
      state_r        <= state_s;
      last_r         <= last_s;
      cnt_r          <= cnt_s;
      grant_r        <= grant_s;
      rot_data_r     <= rot_data_s;
      resp_valid_r   <= resp_valid_s;
      resp_data_r    <= resp_data_s;
      resp_control_r <= resp_control_s;
      resp_error_r   <= resp_error_s;
      busy_r         <= busy_s;
      err_count_r    <= err_count_s;
    end
  end

  assign grant        = grant_r;
  assign rot_data_in  = rot_data_r;
  assign resp_valid   = resp_valid_r;
  assign resp_data    = resp_data_r;
  assign resp_control = resp_control_r;
  assign resp_error   = resp_error_r;
  assign busy         = busy_r;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_rot_arbiter.sv
// Scoreboard bench for rot_arbiter: a transaction-level round-robin model predicts every response,
// a negedge monitor pops and compares; a behavioural rotator stands in for the real one.
module tb_rot_arbiter;
  localparam int BUS = 60;
  localparam int WS  = 6;
  localparam int WN  = 10;
  localparam int NR  = 4;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR*BUS-1:0] req_data;
  logic [NR-1:0]   grant;
  logic [BUS-1:0]  rot_data_in;
  logic [BUS-1:0]  rot_data_out;
  logic [WN-1:0]   rot_control_out;
  logic            rot_error;
  logic [NR-1:0]   resp_valid;
  logic [BUS-1:0]  resp_data;
  logic [WN-1:0]   resp_control;
  logic            resp_error;
  logic            busy;
  logic [7:0]      err_count;

  logic            err_en;
  bit              keep;
  bit              rand_mode;
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;

  typedef struct packed {
    logic [NR-1:0]  who;
    logic [BUS-1:0] data;
    logic [WN-1:0]  ctrl;
    logic           err;
    logic [7:0]     errc;
  } exp_t;
  exp_t exp_q[$];

  rot_arbiter #(.BUS_SIZE(BUS), .WORD_SIZE(WS), .NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
    .rot_data_in(rot_data_in), .rot_data_out(rot_data_out), .rot_control_out(rot_control_out),
    .rot_error(rot_error), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_control(resp_control), .resp_error(resp_error), .busy(busy), .err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [BUS-1:0] rot_fn(input logic [BUS-1:0] d);
    return {d[BUS-WS-1:0], d[BUS-1:BUS-WS]};
  endfunction

  function automatic logic [WN-1:0] ctrl_fn(input logic [BUS-1:0] d);
    logic [WN-1:0] c;
    for (int w = 0; w < WN; w++) c[w] = ^d[w*WS +: WS];
    return c;
  endfunction

  // Behavioural rotator with LAT register stages.
  logic [BUS-1:0] pd [LAT];
  logic [WN-1:0]  pc [LAT];
  logic           pe [LAT];
  always_ff @(posedge clk) begin
    pd[0] <= rot_fn(rot_data_in);
    pc[0] <= ctrl_fn(rot_data_in);
    pe[0] <= err_en & rot_data_in[0];
    for (int s = 1; s < LAT; s++) begin
      pd[s] <= pd[s-1];
      pc[s] <= pc[s-1];
      pe[s] <= pe[s-1];
    end
  end
  assign rot_data_out    = pd[LAT-1];
  assign rot_control_out = pc[LAT-1];
  assign rot_error       = pe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference model: one transaction per LAT+3 cycles, strict round-robin from the last winner.
  initial begin
    int m_last, m_hold, m_errc, w, idx;
    exp_t e;
    logic [BUS-1:0] d;
    m_last = NR - 1; m_hold = 0; m_errc = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        exp_q.delete();
        m_last = NR - 1; m_hold = 0; m_errc = 0;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (req != '0) begin
        w = -1;
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (w < 0 && req[idx]) w = idx;
        end
        d      = req_data[w*BUS +: BUS];
        e.who  = 4'b0001 << w;
        e.data = rot_fn(d);
        e.ctrl = ctrl_fn(d);
        e.err  = err_en & d[0];
        if (e.err && m_errc < 255) m_errc++;
        e.errc = m_errc[7:0];
        exp_q.push_back(e);
        m_last = w;
        m_hold = LAT + 2;
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on each response strobe.
  initial begin
    int wc;
    exp_t e;
    wc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        wc = 0;
      end else begin
        chk("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
        chk("busy_vs_grant", 64'(busy), 64'(|grant));
        if (resp_valid != '0) begin
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", 64'(resp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            wc = 0;
            chk("resp_valid", 64'(resp_valid), 64'(e.who));
            chk("resp_grant", 64'(grant), 64'(e.who));
            chk("resp_data", 64'(resp_data), 64'(e.data));
            chk("resp_control", 64'(resp_control), 64'(e.ctrl));
            chk("resp_error", 64'(resp_error), 64'(e.err));
            chk("err_count", 64'(err_count), 64'(e.errc));
          end
        end else if (exp_q.size() > 0) begin
          wc++;
          if (wc > LAT + 4) begin
            chk("resp_timeout", 64'(wc), 64'd0);
            void'(exp_q.pop_front());
            wc = 0;
          end
        end
      end
    end
  end

  task automatic set_data(input int i);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    req_data[i*BUS +: BUS] = r[BUS-1:0];
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (rand_mode) begin
        if (resp_valid[i]) begin
          if ($urandom_range(3) == 0) set_data(i);
          else req[i] = 1'b0;
        end else if (req[i] && grant[i]) begin
          if ($urandom_range(9) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            req[i] = 1'b1;
            set_data(i);
          end
        end
        if ($urandom_range(7) == 0) set_data(i);
      end else if (resp_valid[i] && !keep) begin
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_resp(input logic [NR-1:0] who);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 12 && !seen; t++) begin
      tick();
      if (resp_valid == who) seen = 1'b1;
    end
    chk("wait_resp", 64'(seen), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    tick();
    tick();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rot_data_in", 64'(rot_data_in), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_control", 64'(resp_control), 64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] gseq [8];
    int gcyc [8];
    int gcount;
    logic [NR-1:0] prev_g;
    reset = 1'b0; req = '0; req_data = '0; err_en = 1'b0; keep = 1'b0; rand_mode = 1'b0;

    // single request, exact timing
    do_reset();
    req_data[59:0] = 60'h0123456789ABCDE;
    req = 4'b0001;
    tick();
    chk("t1_grant_e1", 64'(grant), 64'h1);
    chk("t1_rot_data_in", 64'(rot_data_in), 64'h0123456789ABCDE);
    chk("t1_busy_e1", 64'(busy), 64'd1);
    chk("t1_no_resp_e1", 64'(resp_valid), 64'd0);
    tick();
    chk("t1_no_resp_e2", 64'(resp_valid), 64'd0);
    tick();
    chk("t1_resp_e3", 64'(resp_valid), 64'h1);
    tick();
    chk("t1_busy_e4", 64'(busy), 64'd0);
    chk("t1_grant_e4", 64'(grant), 64'd0);

    // all four requesting continuously
    do_reset();
    for (int i = 0; i < NR; i++) set_data(i);
    for (int i = 0; i < 8; i++) begin gseq[i] = '0; gcyc[i] = 0; end
    keep = 1'b1;
    gcount = 0;
    prev_g = '0;
    req = 4'b1111;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (prev_g == '0 && grant != '0 && gcount < 8) begin
        gseq[gcount] = grant;
        gcyc[gcount] = cyc;
        gcount++;
      end
      prev_g = grant;
    end
    req = '0;
    keep = 1'b0;
    chk("rr_count", 64'(gcount), 64'd5);
    for (int k = 0; k < 5; k++) chk("rr_order", 64'(gseq[k]), 64'(4'b0001 << (k % NR)));
    for (int k = 1; k < 5; k++) chk("rr_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'(LAT + 3));
    repeat (4) tick();

    // pointer fairness after serving requester 2
    set_data(2);
    req = 4'b0100;
    wait_resp(4'b0100);
    set_data(0);
    req = 4'b0101;
    tick();
    tick();
    chk("fair_grant", 64'(grant), 64'h1);
    repeat (10) tick();
    req = '0;
    repeat (4) tick();

    // requester 1 drops req right after grant
    set_data(1);
    req = 4'b0010;
    tick();
    chk("drop_grant", 64'(grant), 64'h2);
    req[1] = 1'b0;
    tick();
    tick();
    chk("drop_resp", 64'(resp_valid), 64'h2);
    tick();
    tick();
    chk("drop_idle_grant", 64'(grant), 64'd0);
    chk("drop_idle_busy", 64'(busy), 64'd0);

    // error path and saturation
    do_reset();
    err_en = 1'b1;
    for (int n = 1; n <= 257; n++) begin
      set_data(3);
      req_data[3*BUS] = 1'b1;
      req[3] = 1'b1;
      wait_resp(4'b1000);
      if (n == 3) chk("err_count_3", 64'(err_count), 64'd3);
      tick();
    end
    chk("err_count_sat", 64'(err_count), 64'd255);
    err_en = 1'b0;

    // reset asserted mid-WAIT
    do_reset();
    set_data(0);
    req = 4'b0001;
    tick();
    chk("midrst_grant_pre", 64'(grant), 64'h1);
    reset = 1'b0;
    req = '0;
    #1;
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("midrst_no_resp1", 64'(resp_valid), 64'd0);
    tick();
    chk("midrst_no_resp2", 64'(resp_valid), 64'd0);
    reset = 1'b1;
    set_data(3);
    req = 4'b1000;
    tick();
    chk("midrst_after_grant", 64'(grant), 64'h8);
    repeat (6) tick();

    // randomized traffic
    do_reset();
    err_en = 1'b1;
    rand_mode = 1'b1;
    repeat (400) tick();
    rand_mode = 1'b0;
    req = '0;
    for (int t = 0; t < 30 && exp_q.size() > 0; t++) tick();
    repeat (2) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rot_arbiter.md
Name: rot_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one muxpar word rotator between NUM_REQ requesters.
- Latches the winning requester's bus and drives it into the rotator.
- Waits the rotator's register latency, then captures data_out, control_out and error_out.
- Returns the result to the granted requester with a one-cycle response strobe, and keeps a saturating count of rotator errors.

Parameters:
- BUS_SIZE, 60, data bus width in bits
- WORD_SIZE, 6, word width in bits; WORD_NUM = BUS_SIZE/WORD_SIZE (10)
- NUM_REQ, 4, number of requesters (2..8)
- LATENCY, 1, rotator register stages between data_in and data_out (>=1)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  level request per requester
- req_data  input  NUM_REQ*BUS_SIZE  requester i's bus at bits [i*BUS_SIZE +: BUS_SIZE]
- grant  output  NUM_REQ  one-hot; current owner of the rotator
- rot_data_in  output  BUS_SIZE  to rotator data_in
- rot_data_out  input  BUS_SIZE  from rotator data_out
- rot_control_out  input  WORD_NUM  from rotator control_out
- rot_error  input  1  from rotator error_out
- resp_valid  output  NUM_REQ  one-hot, one-cycle result strobe
- resp_data  output  BUS_SIZE  captured rotator data
- resp_control  output  WORD_NUM  captured rotator control
- resp_error  output  1  captured rotator error
- busy  output  1  high whenever state is not IDLE
- err_count  output  8  saturating count of responses with resp_error=1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; grant, resp_valid, rot_data_in, resp_data, resp_control, resp_error, busy and err_count all 0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, WAIT, RESP. All registered; no combinational path from req to grant.
- IDLE, at edge t with req!=0:
  - Select the first asserted req scanning last+1, last+2, ... modulo NUM_REQ.
  - grant<=onehot(sel); rot_data_in<=req_data[sel]; last<=sel; cnt<=LATENCY; state<=WAIT.
  - With req==0, stay in IDLE and hold all outputs.
- WAIT:
  - cnt decrements each edge; rot_data_in and grant are held stable.
  - At the edge where cnt==0 (edge t+LATENCY+1): resp_data<=rot_data_out, resp_control<=rot_control_out, resp_error<=rot_error, resp_valid<=grant, state<=RESP.
  - If rot_error=1, err_count increments, saturating at 255.
- RESP:
  - resp_valid is high for exactly one cycle. At the next edge resp_valid<=0, grant<=0, state<=IDLE.
  - resp_data, resp_control and resp_error hold until the next capture.
  - rot_data_in holds its last value.
- Throughput: one transaction per LATENCY+3 cycles. The next grant is sampled at the first IDLE edge.
- Handshake:
  - The requester keeps req high until its resp_valid, then deasserts.
  - A req still high after resp_valid is treated as a new request, but the pointer has moved past it, so other pending requesters win first.
- req dropped while granted: the transaction completes normally (data already latched) and resp_valid still fires.
- req_data changing while granted: no effect.
- Simultaneous requests: strict round-robin, with no starvation. Worst-case wait is (NUM_REQ-1)*(LATENCY+3) cycles after the current transaction.
- grant and resp_valid are never multi-hot. busy=1 exactly in WAIT and RESP.
- Reset asserted mid-transaction: the transaction is aborted immediately with no resp_valid, and all state returns to reset values.

Test Plan:
- Reset then single request: req=4'b0001, req_data[59:0]=60'h0123456789ABCDE, LATENCY=1.
  - grant=0001 from edge 1; rot_data_in=60'h0123456789ABCDE.
  - resp_valid=0001 in the cycle after edge 3; resp_data equals the rotator output; busy high from edge 1 to edge 4.
- All four requesting, held high through their responses:
  - grant order 0,1,2,3,0; each resp_valid is one cycle; consecutive grants are 4 cycles apart.
- Pointer fairness: after serving requester 2, req=4'b0101 -> grant=0001 (requester 0), not requester 2.
- Requester 1 drops req the cycle after grant:
  - resp_valid=0010 still fires with the latched data; the next IDLE with req=0 leaves grant=0.
- Error path:
  - Force rot_error=1 on 3 transactions: resp_error=1 on each and err_count=3.
  - Preload 255 errors: err_count stays at 255.
- Reset mid-WAIT: drop reset low during cnt>0 -> grant, busy and resp_valid go to 0 immediately.
  - No response is issued; after release with req=4'b1000, grant=1000.
